// File: rtl/dmem_responder_pkg.sv
// Shared types, constants and address-decode helper for the data-memory responder.
package dmem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    // Word-aligned and inside [base, base + depth*4); 33-bit math keeps the top of the map from wrapping.
    function automatic logic addr_legal(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] depth);
        logic [32:0] off_v;
        logic [32:0] span_v;
        off_v  = {1'b0, addr} - {1'b0, base};
        span_v = {1'b0, depth} << 2;
        return (addr >= base) && (off_v < span_v) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core data-memory request/ready bus between the core (master) and the responder (slave).
interface dmem_responder_if #(
    parameter int DWidth = 32
);
    logic              req_i;
    logic              write_i;
    logic [DWidth-1:0] addr_i;
    logic [DWidth-1:0] wdata_i;
    logic              ready_o;
    logic [DWidth-1:0] rdata_o;
    logic              err_o;
    logic              busy_o;
    logic [DWidth-1:0] acc_cnt_o;

    modport master (
        output req_i, write_i, addr_i, wdata_i,
        input  ready_o, rdata_o, err_o, busy_o, acc_cnt_o
    );

    modport slave (
        input  req_i, write_i, addr_i, wdata_i,
        output ready_o, rdata_o, err_o, busy_o, acc_cnt_o
    );
endinterface

// File: rtl/dmem_responder_array.sv
// Single-port word array: combinational read on idx, write on the rising edge when we is set.
module dmem_array #(
    parameter int DWidth     = 32,
    parameter int DepthWords = 1024
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [$clog2(DepthWords)-1:0] idx,
    input  logic [DWidth-1:0]             wdata,
    output logic [DWidth-1:0]             rdata
);
    logic [DWidth-1:0] mem_r [DepthWords];

    // Store port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[idx] <= wdata;
        end
    end

    assign rdata = mem_r[idx];
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits Latency cycles, then pulses ready
// with read data or error, committing stores on that same pulse.
module dmem_responder
    import dmem_resp_pkg::*;
#(
    parameter int          DWidth     = 32,
    parameter logic [31:0] BaseAddr   = 32'h0000_4000,
    parameter int          DepthWords = 1024,
    parameter int          Latency    = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    dmem_responder_if.slave  bus
);
    localparam int         IdxW    = $clog2(DepthWords);
    localparam logic [3:0] LatInit = 4'(Latency - 1);
    localparam logic       Lat1    = (Latency == 1);

    state_e            state_r;
    state_e            state_s;
    logic [3:0]        lat_cnt_r;
    logic              wr_r;
    logic [DWidth-1:0] addr_r;
    logic [DWidth-1:0] wdata_r;
    logic              legal_r;
    logic [DWidth-1:0] rdata_r;
    logic [DWidth-1:0] acc_cnt_r;

    logic              accept_s;
    logic              resp_s;
    logic              we_s;
    logic [DWidth-1:0] off_s;
    logic [IdxW-1:0]   idx_s;
    logic [DWidth-1:0] arr_rdata_s;
    logic [DWidth-1:0] rdata_s;

    assign off_s = addr_r - BaseAddr;
    assign idx_s = IdxW'(off_s >> 2);

    dmem_array #(
        .DWidth     (DWidth),
        .DepthWords (DepthWords)
    ) u_array (
        .clk   (clk_i),
        .we    (we_s),
        .idx   (idx_s),
        .wdata (wdata_r),
        .rdata (arr_rdata_s)
    );

    // Next-state decode and response datapath
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req_i) begin
                    accept_s = 1'b1;
                    state_s  = Lat1 ? RESP : WAIT;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (lat_cnt_r <= 4'd1) begin
                    state_s = RESP;
                end else begin
                    state_s = WAIT;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase

        resp_s = (state_r == RESP);
        // A reset landing on the response edge must not let the store reach the array.
        we_s   = resp_s && wr_r && legal_r && !rst_i;
        if (resp_s && !wr_r) begin
            rdata_s = legal_r ? arr_rdata_s : ERR_DATA;
        end else begin
            rdata_s = rdata_r;
        end
    end

    // State, latency counter and held read data
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= IDLE;
            lat_cnt_r <= 4'd0;
            rdata_r   <= {DWidth{1'b0}};
        end else begin
            state_r <= state_s;
            rdata_r <= rdata_s;
            if (accept_s) begin
                lat_cnt_r <= LatInit;
            end else if (state_r == WAIT) begin
                lat_cnt_r <= lat_cnt_r - 4'd1;
            end else begin
                lat_cnt_r <= lat_cnt_r;
            end
        end
    end

    // Request capture at acceptance; legality is decided once here
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_r    <= 1'b0;
            addr_r  <= {DWidth{1'b0}};
            wdata_r <= {DWidth{1'b0}};
            legal_r <= 1'b0;
        end else if (accept_s) begin
            wr_r    <= bus.write_i;
            addr_r  <= bus.addr_i;
            wdata_r <= bus.wdata_i;
            legal_r <= addr_legal(bus.addr_i, BaseAddr, 32'(DepthWords));
        end else begin
            wr_r    <= wr_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
            legal_r <= legal_r;
        end
    end

    // Saturating completed-access counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_cnt_r <= {DWidth{1'b0}};
        end else if (resp_s && (acc_cnt_r != {DWidth{1'b1}})) begin
            acc_cnt_r <= acc_cnt_r + {{(DWidth-1){1'b0}}, 1'b1};
        end else begin
            acc_cnt_r <= acc_cnt_r;
        end
    end

    assign bus.ready_o   = resp_s;
    assign bus.err_o     = resp_s && !legal_r;
    assign bus.busy_o    = (state_r != IDLE);
    assign bus.rdata_o   = rdata_s;
    assign bus.acc_cnt_o = acc_cnt_r;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: two responders (Latency 2 and Latency 1) checked against a word-level memory model.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_responder_if #(.DWidth(32)) bus2 ();
    dmem_responder_if #(.DWidth(32)) bus1 ();

    dmem_responder #(.Latency(2)) dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2));
    dmem_responder #(.Latency(1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));

    int total = 0;
    int bad   = 0;

    // Reference model, index 0 = Latency-2 instance, 1 = Latency-1 instance
    logic [31:0] mem_m      [2][1024];
    bit          known_m    [2][1024];
    logic [31:0] last_rd    [2];
    bit          last_known [2];
    int          acc_m      [2];

    function automatic bit legal_m(input logic [31:0] a);
        longint unsigned ua;
        ua = a;
        return (ua >= 64'h4000) && (ua < 64'h4000 + 64'd1024 * 64'd4) && (ua % 4 == 0);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            last_rd[s]    = 32'h0;
            last_known[s] = 1'b1;
            acc_m[s]      = 0;
        end
    endtask

    task automatic model_step(input int s, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                              output bit e_err, output logic [31:0] e_rd, output bit e_chk);
        int w;
        e_err = !legal_m(a);
        acc_m[s]++;
        if (wr) begin
            if (!e_err) begin
                w = int'((a - 32'h4000) / 4);
                mem_m[s][w]   = wd;
                known_m[s][w] = 1'b1;
            end
            e_rd  = last_rd[s];
            e_chk = last_known[s];
        end else if (e_err) begin
            e_rd  = 32'hDEAD_BEEF;
            e_chk = 1'b1;
            last_rd[s]    = e_rd;
            last_known[s] = 1'b1;
        end else begin
            w = int'((a - 32'h4000) / 4);
            e_rd  = mem_m[s][w];
            e_chk = known_m[s][w];
            last_rd[s]    = e_rd;
            last_known[s] = e_chk;
        end
    endtask

    task automatic set_req(input int s, input bit r, input bit wr, input logic [31:0] a, input logic [31:0] wd);
        if (s == 1) begin
            bus1.req_i = r; bus1.write_i = wr; bus1.addr_i = a; bus1.wdata_i = wd;
        end else begin
            bus2.req_i = r; bus2.write_i = wr; bus2.addr_i = a; bus2.wdata_i = wd;
        end
    endtask

    function automatic logic get_ready(input int s);
        return (s == 1) ? bus1.ready_o : bus2.ready_o;
    endfunction

    // One transaction: lat = cycles from acceptance to ready (-1 on timeout), dbl = ready still high next cycle
    task automatic drive(input int s, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic err, output logic [31:0] rd, output logic dbl);
        @(negedge clk);
        set_req(s, 1'b1, wr, a, wd);
        lat = -1; err = 1'b0; rd = 32'h0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (get_ready(s)) begin
                lat = n;
                err = (s == 1) ? bus1.err_o : bus2.err_o;
                rd  = (s == 1) ? bus1.rdata_o : bus2.rdata_o;
                break;
            end
        end
        set_req(s, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        dbl = get_ready(s);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_req(0, 1'b1, 1'b1, 32'h4000, 32'h5555_5555);
        set_req(1, 1'b1, 1'b1, 32'h4000, 32'h5555_5555);
        repeat (3) @(negedge clk);
        total += 5;
        if (bus2.ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", bus2.ready_o); end
        if (bus2.err_o !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", bus2.err_o); end
        if (bus2.busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus2.busy_o); end
        if (bus2.rdata_o !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", bus2.rdata_o); end
        if (bus2.acc_cnt_o !== 32'h0) begin bad++; $display("FAIL rst_acc got=%h want=0", bus2.acc_cnt_o); end
        rst = 1'b0;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        model_reset();
        @(negedge clk);
        total += 2;
        if (bus2.busy_o !== 1'b0) begin bad++; $display("FAIL rst_req_ignored2 busy got=%b want=0", bus2.busy_o); end
        if (bus1.busy_o !== 1'b0) begin bad++; $display("FAIL rst_req_ignored1 busy got=%b want=0", bus1.busy_o); end
    endtask

    task automatic test_store_load();
        logic [31:0] addrs [4] = '{32'h4000, 32'h4004, 32'h4008, 32'h400C};
        logic [31:0] vals  [4] = '{32'h1234_5678, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
        int lat; logic err, dbl; logic [31:0] rd, e_rd; bit e_err, e_chk;
        for (int i = 0; i < 4; i++) begin
            model_step(0, 1'b1, addrs[i], vals[i], e_err, e_rd, e_chk);
            drive(0, 1'b1, addrs[i], vals[i], lat, err, rd, dbl);
            total += 3;
            if (lat !== 2) begin bad++; $display("FAIL st_lat i=%0d got=%0d want=2", i, lat); end
            if (err !== e_err) begin bad++; $display("FAIL st_err i=%0d got=%b want=%b", i, err, e_err); end
            if (e_chk && rd !== e_rd) begin bad++; $display("FAIL st_hold i=%0d got=%h want=%h", i, rd, e_rd); end
        end
        model_step(0, 1'b0, 32'h4000, 32'h0, e_err, e_rd, e_chk);
        drive(0, 1'b0, 32'h4000, 32'h0, lat, err, rd, dbl);
        total += 4;
        if (lat !== 2) begin bad++; $display("FAIL ld_lat got=%0d want=2", lat); end
        if (err !== 1'b0) begin bad++; $display("FAIL ld_err got=%b want=0", err); end
        if (rd !== 32'h1234_5678) begin bad++; $display("FAIL ld_data got=%h want=12345678", rd); end
        if (dbl !== 1'b0) begin bad++; $display("FAIL ld_pulse got=%b want=0", dbl); end
    endtask

    task automatic test_illegal();
        logic [31:0] addrs [5] = '{32'h3FFC, 32'h4002, 32'h5000, 32'h4002, 32'h5000};
        bit          wrs   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int lat; logic err, dbl; logic [31:0] rd, e_rd; bit e_err, e_chk;
        for (int i = 0; i < 5; i++) begin
            model_step(0, wrs[i], addrs[i], 32'h0BAD_0BAD, e_err, e_rd, e_chk);
            drive(0, wrs[i], addrs[i], 32'h0BAD_0BAD, lat, err, rd, dbl);
            total += 3;
            if (lat !== 2) begin bad++; $display("FAIL ill_lat i=%0d got=%0d want=2", i, lat); end
            if (err !== 1'b1) begin bad++; $display("FAIL ill_err i=%0d got=%b want=1", i, err); end
            if (e_chk && rd !== e_rd) begin bad++; $display("FAIL ill_rdata i=%0d got=%h want=%h", i, rd, e_rd); end
        end
        model_step(0, 1'b0, 32'h4000, 32'h0, e_err, e_rd, e_chk);
        drive(0, 1'b0, 32'h4000, 32'h0, lat, err, rd, dbl);
        total++;
        if (rd !== e_rd) begin bad++; $display("FAIL ill_nomod got=%h want=%h", rd, e_rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [4] = '{32'h4000, 32'h4004, 32'h4008, 32'h400C};
        logic [31:0] e_rd; bit e_err, e_chk;
        int k = 0; int n = 0; logic prev = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_reset();
        set_req(0, 1'b1, 1'b0, addrs[0], 32'h0);
        while (k < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (bus2.ready_o) begin
                model_step(0, 1'b0, addrs[k], 32'h0, e_err, e_rd, e_chk);
                total += 4;
                if (n !== 2 + 3 * k) begin bad++; $display("FAIL b2b_time k=%0d got=%0d want=%0d", k, n, 2 + 3 * k); end
                if (prev !== 1'b0) begin bad++; $display("FAIL b2b_double k=%0d got=1 want=0", k); end
                if (bus2.err_o !== e_err) begin bad++; $display("FAIL b2b_err k=%0d got=%b want=%b", k, bus2.err_o, e_err); end
                if (e_chk && bus2.rdata_o !== e_rd) begin bad++; $display("FAIL b2b_data k=%0d got=%h want=%h", k, bus2.rdata_o, e_rd); end
                k++;
                if (k < 4) set_req(0, 1'b1, 1'b0, addrs[k], 32'h0);
                else set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
            end
            prev = bus2.ready_o;
        end
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        total += 2;
        if (k !== 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", k); end
        if (bus2.acc_cnt_o !== 32'(acc_m[0])) begin bad++; $display("FAIL b2b_acc got=%0d want=%0d", bus2.acc_cnt_o, acc_m[0]); end
    endtask

    task automatic test_reset_inflight();
        int lat; logic err, dbl; logic [31:0] rd, e_rd; bit e_err, e_chk;
        int seen = 0;
        model_step(0, 1'b1, 32'h4010, 32'h0A0A_0A0A, e_err, e_rd, e_chk);
        drive(0, 1'b1, 32'h4010, 32'h0A0A_0A0A, lat, err, rd, dbl);
        @(negedge clk);
        set_req(0, 1'b1, 1'b1, 32'h4010, 32'hFFFF_0000);
        @(negedge clk);
        if (bus2.ready_o) seen++;
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                total++;
                if (bus2.acc_cnt_o !== 32'h0) begin bad++; $display("FAIL rif_acc got=%0d want=0", bus2.acc_cnt_o); end
            end
            if (bus2.ready_o) seen++;
            @(negedge clk);
        end
        total += 2;
        if (seen !== 0) begin bad++; $display("FAIL rif_ready got=%0d pulses want=0", seen); end
        if (bus2.busy_o !== 1'b0) begin bad++; $display("FAIL rif_busy got=%b want=0", bus2.busy_o); end
        model_step(0, 1'b0, 32'h4010, 32'h0, e_err, e_rd, e_chk);
        drive(0, 1'b0, 32'h4010, 32'h0, lat, err, rd, dbl);
        total++;
        if (rd !== e_rd) begin bad++; $display("FAIL rif_old got=%h want=%h", rd, e_rd); end
    endtask

    task automatic test_latency1();
        int lat; logic err, dbl; logic [31:0] rd, e_rd; bit e_err, e_chk;
        model_step(1, 1'b1, 32'h4FFC, 32'hCAFE_F00D, e_err, e_rd, e_chk);
        drive(1, 1'b1, 32'h4FFC, 32'hCAFE_F00D, lat, err, rd, dbl);
        total += 2;
        if (lat !== 1) begin bad++; $display("FAIL l1_st_lat got=%0d want=1", lat); end
        if (err !== 1'b0) begin bad++; $display("FAIL l1_st_err got=%b want=0", err); end
        model_step(1, 1'b0, 32'h4FFC, 32'h0, e_err, e_rd, e_chk);
        drive(1, 1'b0, 32'h4FFC, 32'h0, lat, err, rd, dbl);
        total += 4;
        if (lat !== 1) begin bad++; $display("FAIL l1_ld_lat got=%0d want=1", lat); end
        if (err !== 1'b0) begin bad++; $display("FAIL l1_ld_err got=%b want=0", err); end
        if (rd !== 32'hCAFE_F00D) begin bad++; $display("FAIL l1_ld_data got=%h want=cafef00d", rd); end
        if (dbl !== 1'b0) begin bad++; $display("FAIL l1_pulse got=%b want=0", dbl); end
    endtask

    task automatic test_random();
        logic [31:0] bad_addrs [4] = '{32'h3FFC, 32'h4002, 32'h5000, 32'h0000_0010};
        int lat; logic err, dbl; logic [31:0] rd, e_rd, a, wd; bit e_err, e_chk, wr;
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            a  = 32'h4000 + 32'(i * 4);
            model_step(0, 1'b1, a, wd, e_err, e_rd, e_chk);
            drive(0, 1'b1, a, wd, lat, err, rd, dbl);
            total++;
            if (err !== e_err) begin bad++; $display("FAIL rnd_fill_err i=%0d got=%b want=%b", i, err, e_err); end
        end
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            if ($urandom_range(0, 4) == 0) a = bad_addrs[$urandom_range(0, 3)];
            else a = 32'h4000 + 32'($urandom_range(0, 15) * 4);
            model_step(0, wr, a, wd, e_err, e_rd, e_chk);
            drive(0, wr, a, wd, lat, err, rd, dbl);
            total += 4;
            if (lat !== 2) begin bad++; $display("FAIL rnd_lat i=%0d got=%0d want=2", i, lat); end
            if (err !== e_err) begin bad++; $display("FAIL rnd_err i=%0d a=%h got=%b want=%b", i, a, err, e_err); end
            if (e_chk && rd !== e_rd) begin bad++; $display("FAIL rnd_rdata i=%0d a=%h got=%h want=%h", i, a, rd, e_rd); end
            if (dbl !== 1'b0) begin bad++; $display("FAIL rnd_pulse i=%0d got=%b want=0", i, dbl); end
        end
        @(negedge clk);
        total++;
        if (bus2.acc_cnt_o !== 32'(acc_m[0])) begin bad++; $display("FAIL rnd_acc got=%0d want=%0d", bus2.acc_cnt_o, acc_m[0]); end
    endtask

    initial begin
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        model_reset();
        test_reset();
        test_store_load();
        test_illegal();
        test_back_to_back();
        test_reset_inflight();
        test_latency1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
